// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm controller slice.
package alarm_pkg;

    localparam int unsigned HR_W   = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned SNZ_W  = 9;  // snooze seconds, up to 511
    localparam int unsigned RING_W = 7;  // ring seconds, up to 127
    localparam int unsigned CNT_W  = 3;  // snoozes per event, up to 7

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRinging,
        StSnooze
    } alarm_state_e;

    function automatic logic time_valid(input logic [HR_W-1:0] hr, input logic [MIN_W-1:0] mn);
        return (hr <= HR_W'(23)) && (mn <= MIN_W'(59));
    endfunction

endpackage

// File: rtl/alarm_tick_cnt.sv
// Loadable, tick-enabled down-counter that saturates at zero.
module alarm_tick_cnt #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: arm / ring / snooze sequencing with registered outputs.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic             alm_set,
    input  logic [HR_W-1:0]  alm_hr_in,
    input  logic [MIN_W-1:0] alm_min_in,
    input  logic             arm_sw,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    output logic             enable,
    output logic             armed,
    output logic             snoozing,
    output logic [HR_W-1:0]  alm_hr,
    output logic [MIN_W-1:0] alm_min,
    output logic [SNZ_W-1:0] snooze_left
);

    localparam logic [SNZ_W-1:0]  SnzLoad = SNZ_W'(SNOOZE_SEC);
    localparam logic [RING_W-1:0] RingTo  = RING_W'(RING_TIMEOUT_SEC);
    localparam logic [CNT_W-1:0]  MaxSnz  = CNT_W'(MAX_SNOOZE);

    alarm_state_e      state_q, state_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic [CNT_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic [HR_W-1:0]   alm_hr_q;
    logic [MIN_W-1:0]  alm_min_q;
    logic              enable_q, armed_q, snoozing_q;
    logic              match;
    logic              snz_load, snz_clr;
    logic [SNZ_W-1:0]  snz_left;

    assign match = sec_tick && (cur_hr == alm_hr_q) && (cur_min == alm_min_q) && (cur_sec == '0);

    always_comb begin
        state_d   = state_q;
        ring_d    = ring_q;
        snz_cnt_d = snz_cnt_q;
        snz_load  = 1'b0;

        if (!arm_sw) begin
            state_d   = StIdle;
            ring_d    = '0;
            snz_cnt_d = '0;
        end else begin
            unique case (state_q)
                // Arming cycle deliberately ignores match.
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (match) begin
                        state_d   = StRinging;
                        ring_d    = '0;
                        snz_cnt_d = '0;
                    end
                end
                StRinging: begin
                    if (stop_btn) begin
                        state_d = StArmed;
                        ring_d  = '0;
                    end else if (snooze_btn && (snz_cnt_q < MaxSnz)) begin
                        state_d   = StSnooze;
                        snz_load  = 1'b1;
                        snz_cnt_d = snz_cnt_q + CNT_W'(1);
                        ring_d    = '0;
                    end else if (sec_tick) begin
                        ring_d = (ring_q != '1) ? ring_q + RING_W'(1) : ring_q;
                        if (ring_d >= RingTo) begin
                            state_d = StArmed;
                            ring_d  = '0;
                        end
                    end
                end
                StSnooze: begin
                    if (stop_btn) begin
                        state_d = StArmed;
                    end else if (sec_tick && (snz_left == SNZ_W'(1))) begin
                        state_d = StRinging;
                        ring_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Holding the counter in clear outside SNOOZE keeps snooze_left at 0 there.
        snz_clr = (state_d != StSnooze);
    end

    alarm_tick_cnt #(
        .W (SNZ_W)
    ) u_snz_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (snz_clr),
        .load     (snz_load),
        .load_val (SnzLoad),
        .tick     (sec_tick),
        .count    (snz_left)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ring_q     <= '0;
            snz_cnt_q  <= '0;
            alm_hr_q   <= '0;
            alm_min_q  <= '0;
            enable_q   <= 1'b0;
            armed_q    <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            snz_cnt_q  <= snz_cnt_d;
            enable_q   <= (state_d == StRinging);
            armed_q    <= (state_d != StIdle);
            snoozing_q <= (state_d == StSnooze);
            if (alm_set && time_valid(alm_hr_in, alm_min_in)) begin
                alm_hr_q  <= alm_hr_in;
                alm_min_q <= alm_min_in;
            end
        end
    end

    assign enable      = enable_q;
    assign armed       = armed_q;
    assign snoozing    = snoozing_q;
    assign alm_hr      = alm_hr_q;
    assign alm_min     = alm_min_q;
    assign snooze_left = snz_left;

endmodule
